// File: rtl/bpu_pkg.sv
// Shared types, counter constants and the PHT index function for the
// gshare/BTB branch prediction unit.
package bpu_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bpu_state_e;

   typedef enum logic {
      BIMODAL = 1'b0,
      GSHARE  = 1'b1
   } bpu_mode_e;

   // Tag field is sized for the widest tag any legal configuration can use
   // (30 pc bits above [1:0]); narrower configurations write the upper bits 0.
   localparam int BTB_TAG_MAX = 30;
   localparam int PHT_IDX_MAX = 30;

   typedef struct packed {
      logic                   valid;
      logic                   jump;
      logic [BTB_TAG_MAX-1:0] tag;
      logic [31:0]            target;
   } btb_entry_t;

   // 2-bit saturating counter states
   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // PHT index from word address (pc[31:2]) and zero-extended history.
   // Bimodal ignores the history; gshare XORs it into the low bits.
   function automatic logic [PHT_IDX_MAX-1:0] pht_idx(
      input logic [PHT_IDX_MAX-1:0] pc_word,
      input logic [PHT_IDX_MAX-1:0] ghr,
      input bpu_mode_e              mode,
      input int                     idx_w
   );
      logic [PHT_IDX_MAX-1:0] mask;
      logic [PHT_IDX_MAX-1:0] base;
      mask = ~({PHT_IDX_MAX{1'b1}} << idx_w);
      base = pc_word;
      if (mode == GSHARE) begin
         base = base ^ ghr;
      end
      return base & mask;
   endfunction

endpackage

// File: rtl/bpu_gshare_btb_if.sv
// Fetch-side lookup, EX-side training and status signals of the branch
// prediction unit. The core drives through master, the predictor is slave.
interface bpu_gshare_btb_if #(
   parameter int GHR_W = 6
);
   // fetch lookup
   logic             stall;
   logic [31:0]      pc;
   logic             pred_taken;
   logic [31:0]      pred_target;
   logic             pred_hit;
   logic [GHR_W-1:0] pred_ghr;
   // EX resolution
   logic             upd_valid;
   logic [31:0]      upd_pc;
   logic             upd_is_branch;
   logic             upd_is_jump;
   logic             upd_taken;
   logic [31:0]      upd_target;
   logic [GHR_W-1:0] upd_ghr;
   logic             upd_mispredict;
   // status
   logic             ready;
   logic [31:0]      perf_branches;
   logic [31:0]      perf_mispred;

   modport master (
      output stall, pc,
      output upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
      output upd_target, upd_ghr, upd_mispredict,
      input  pred_taken, pred_target, pred_hit, pred_ghr,
      input  ready, perf_branches, perf_mispred
   );

   modport slave (
      input  stall, pc,
      input  upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
      input  upd_target, upd_ghr, upd_mispredict,
      output pred_taken, pred_target, pred_hit, pred_ghr,
      output ready, perf_branches, perf_mispred
   );
endinterface

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: combinational tag lookup and one
// synchronous write port. Reads see the old line during a same-index write.
module bpu_btb
   import bpu_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int IW      = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic [IW-1:0]    rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_hit,
   output logic             rd_jump,
   output logic [31:0]      rd_target,
   input  logic             wr_en,
   input  logic [IW-1:0]    wr_idx,
   input  btb_entry_t       wr_entry
);

   btb_entry_t entry_q [ENTRIES];
   btb_entry_t entry_d [ENTRIES];
   btb_entry_t rd_entry;

   // next array contents: single-line overwrite (allocate or sweep clear)
   always_comb begin
      entry_d = entry_q;
      if (wr_en) begin
         entry_d[wr_idx] = wr_entry;
      end
   end

   // line storage; no reset, the INIT sweep clears valid bits
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   // tag compare on the addressed line
   always_comb begin
      rd_entry  = entry_q[rd_idx];
      rd_hit    = rd_entry.valid && (rd_entry.tag == BTB_TAG_MAX'(rd_tag));
      rd_jump   = rd_entry.jump;
      rd_target = rd_entry.target;
   end

endmodule

// File: rtl/bpu_gshare_btb.sv
// Branch prediction unit: tagged BTB plus bimodal/gshare PHT of 2-bit
// counters, speculative global history with recovery, table-clear sweep
// after reset and saturating performance counters.
module bpu_gshare_btb
   import bpu_pkg::*;
#(
   parameter int         PHT_ENTRIES = 64,
   parameter int         BTB_ENTRIES = 16,
   parameter int         GHR_W       = 6,
   parameter int         TAG_W       = 8,
   parameter bpu_mode_e  MODE        = GSHARE,
   parameter logic [1:0] CNT_INIT    = CNT_WNT
) (
   input logic              clk,
   input logic              rstn,
   bpu_gshare_btb_if.slave  bus
);

   localparam int PI      = $clog2(PHT_ENTRIES);
   localparam int BI      = $clog2(BTB_ENTRIES);
   localparam int SWEEP_N = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
   localparam int SW      = $clog2(SWEEP_N);

   function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
      if (up) begin
         return (c == CNT_ST) ? CNT_ST : c + 2'd1;
      end
      return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   bpu_state_e       state_q, state_d;
   logic [SW-1:0]    sweep_q, sweep_d;
   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [31:0]      perf_br_q, perf_br_d;
   logic [31:0]      perf_mispred_q, perf_mispred_d;
   logic [1:0]       pht_q [PHT_ENTRIES];
   logic [1:0]       pht_d [PHT_ENTRIES];

   logic [PI-1:0]    lk_idx;
   logic [PI-1:0]    up_idx;
   logic [31:0]      pc_seq;
   logic             btb_hit;
   logic             btb_jump;
   logic [31:0]      btb_target;
   logic             btb_we;
   logic [BI-1:0]    btb_widx;
   btb_entry_t       btb_wentry;
   logic             pred_taken;
   logic             pred_hit;
   logic [31:0]      pred_target;
   logic             upd_ctl;
   logic             upd_br;
   logic             unused_pc_lo;

   // instruction alignment bits carry no information for prediction
   assign unused_pc_lo = ^{bus.pc[1:0], bus.upd_pc[1:0]};

   assign lk_idx = PI'(pht_idx(bus.pc[31:2], PHT_IDX_MAX'(ghr_q), MODE, PI));
   assign up_idx = PI'(pht_idx(bus.upd_pc[31:2], PHT_IDX_MAX'(bus.upd_ghr), MODE, PI));
   assign pc_seq = {bus.pc[31:2], 2'b00} + 32'd4;

   bpu_btb #(
      .ENTRIES (BTB_ENTRIES),
      .TAG_W   (TAG_W)
   ) u_btb (
      .clk       (clk),
      .rd_idx    (bus.pc[2 +: BI]),
      .rd_tag    (bus.pc[2+BI +: TAG_W]),
      .rd_hit    (btb_hit),
      .rd_jump   (btb_jump),
      .rd_target (btb_target),
      .wr_en     (btb_we),
      .wr_idx    (btb_widx),
      .wr_entry  (btb_wentry)
   );

   // same-cycle prediction; forced to fall-through until the sweep is done
   always_comb begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = pc_seq;
      if (state_q == RUN) begin
         pred_hit   = btb_hit;
         pred_taken = btb_hit & (btb_jump | pht_q[lk_idx][1]);
         if (pred_taken) begin
            pred_target = btb_target;
         end
      end
   end

   assign bus.pred_hit      = pred_hit;
   assign bus.pred_taken    = pred_taken;
   assign bus.pred_target   = pred_target;
   assign bus.pred_ghr      = ghr_q;
   assign bus.ready         = (state_q == RUN);
   assign bus.perf_branches = perf_br_q;
   assign bus.perf_mispred  = perf_mispred_q;

   // branch+jump together is a jump: no PHT train, history restored unshifted
   assign upd_ctl = bus.upd_valid & (bus.upd_is_branch | bus.upd_is_jump);
   assign upd_br  = bus.upd_valid & bus.upd_is_branch & ~bus.upd_is_jump;

   // next state: table sweep in INIT; training, history and perf in RUN
   always_comb begin
      state_d        = state_q;
      sweep_d        = sweep_q;
      ghr_d          = ghr_q;
      perf_br_d      = perf_br_q;
      perf_mispred_d = perf_mispred_q;
      pht_d          = pht_q;
      btb_we         = 1'b0;
      btb_widx       = bus.upd_pc[2 +: BI];
      btb_wentry     = '0;
      case (state_q)
         INIT: begin
            if (int'(sweep_q) < PHT_ENTRIES) begin
               pht_d[PI'(sweep_q)] = CNT_INIT;
            end
            btb_we   = (int'(sweep_q) < BTB_ENTRIES);
            btb_widx = BI'(sweep_q);
            if (int'(sweep_q) == SWEEP_N - 1) begin
               state_d = RUN;
            end else begin
               sweep_d = sweep_q + SW'(1);
            end
         end
         RUN: begin
            if (upd_br) begin
               pht_d[up_idx] = sat_cnt(pht_q[up_idx], bus.upd_taken);
            end
            if (upd_ctl & bus.upd_taken) begin
               btb_we            = 1'b1;
               btb_wentry.valid  = 1'b1;
               btb_wentry.jump   = bus.upd_is_jump;
               btb_wentry.tag    = BTB_TAG_MAX'(bus.upd_pc[2+BI +: TAG_W]);
               btb_wentry.target = bus.upd_target;
            end
            if (upd_ctl) begin
               perf_br_d = sat_inc32(perf_br_q);
               if (bus.upd_mispredict) begin
                  perf_mispred_d = sat_inc32(perf_mispred_q);
               end
            end
            // recovery overrides any speculative shift in the same cycle
            if (bus.upd_valid & bus.upd_mispredict) begin
               ghr_d = upd_br ? {bus.upd_ghr[GHR_W-2:0], bus.upd_taken} : bus.upd_ghr;
            end else if (!bus.stall & btb_hit & !btb_jump) begin
               ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
            end
         end
         default: state_d = INIT;
      endcase
   end

   // control registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= INIT;
         sweep_q        <= '0;
         ghr_q          <= '0;
         perf_br_q      <= '0;
         perf_mispred_q <= '0;
      end else begin
         state_q        <= state_d;
         sweep_q        <= sweep_d;
         ghr_q          <= ghr_d;
         perf_br_q      <= perf_br_d;
         perf_mispred_q <= perf_mispred_d;
      end
   end

   // counter table; cleared by the sweep rather than by reset
   always_ff @(posedge clk) begin
      pht_q <= pht_d;
   end

endmodule

// File: tb/tb_bpu_gshare_btb.sv
// Scoreboard bench for bpu_gshare_btb (gshare mode, default sizes).
module tb_bpu_gshare_btb;
   import bpu_pkg::*;

   logic clk;
   logic rstn;

   bpu_gshare_btb_if #(.GHR_W(6)) bus();

   bpu_gshare_btb #(
      .PHT_ENTRIES (64),
      .BTB_ENTRIES (16),
      .GHR_W       (6),
      .TAG_W       (8),
      .MODE        (GSHARE),
      .CNT_INIT    (2'b01)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        taken;
      logic [31:0] target;
      logic        hit;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   exp_br = 0;
   int   exp_mp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive a lookup, queue its expectation, then pop and compare mid-cycle
   task automatic lookup(input string tag, input logic [31:0] addr,
                         input logic taken, input logic [31:0] target, input logic hit);
      exp_t e;
      bus.pc   = addr;
      e.tag    = tag;
      e.taken  = taken;
      e.target = target;
      e.hit    = hit;
      exp_q.push_back(e);
      #2;
      e = exp_q.pop_front();
      chk({e.tag, "_taken"},  32'(bus.pred_taken), 32'(e.taken));
      chk({e.tag, "_target"}, bus.pred_target,     e.target);
      chk({e.tag, "_hit"},    32'(bus.pred_hit),   32'(e.hit));
   endtask

   // one EX resolution, applied at the next rising edge
   task automatic upd(input logic [31:0] a, input logic br, input logic jmp, input logic tk,
                      input logic [31:0] tgt, input logic [5:0] g, input logic mp);
      bus.upd_valid      = 1'b1;
      bus.upd_pc         = a;
      bus.upd_is_branch  = br;
      bus.upd_is_jump    = jmp;
      bus.upd_taken      = tk;
      bus.upd_target     = tgt;
      bus.upd_ghr        = g;
      bus.upd_mispredict = mp;
      if (br | jmp) begin
         exp_br++;
         if (mp) exp_mp++;
      end
      tick();
      bus.upd_valid      = 1'b0;
      bus.upd_mispredict = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!bus.ready && n < 200) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'd64);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn               = 1'b0;
      bus.stall          = 1'b1;
      bus.pc             = 32'h40;
      bus.upd_valid      = 1'b0;
      bus.upd_pc         = '0;
      bus.upd_is_branch  = 1'b0;
      bus.upd_is_jump    = 1'b0;
      bus.upd_taken      = 1'b0;
      bus.upd_target     = '0;
      bus.upd_ghr        = '0;
      bus.upd_mispredict = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_ready",   32'(bus.ready),      32'd0);
      chk("rst_taken",   32'(bus.pred_taken), 32'd0);
      chk("rst_target",  bus.pred_target,     32'h44);
      chk("rst_hit",     32'(bus.pred_hit),   32'd0);
      chk("rst_ghr",     32'(bus.pred_ghr),   32'd0);
      chk("rst_perf_br", bus.perf_branches,   32'd0);
      chk("rst_perf_mp", bus.perf_mispred,    32'd0);

      rstn = 1'b1;
      wait_ready("init_len");
      lookup("post_init", 32'h40, 1'b0, 32'h44, 1'b0);

      // train taken, then not-taken, then saturate
      repeat (2) upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 6'd0, 1'b0);
      lookup("train_t", 32'h100, 1'b1, 32'h80, 1'b1);
      repeat (3) upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 6'd0, 1'b0);
      lookup("train_nt", 32'h100, 1'b0, 32'h104, 1'b1);
      repeat (5) upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 6'd0, 1'b0);
      upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 6'd0, 1'b0);
      lookup("sat_hi", 32'h100, 1'b1, 32'h80, 1'b1);

      // jump overrides a strongly not-taken counter and never shifts history
      repeat (2) upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 6'd0, 1'b0);
      lookup("pht_zero", 32'h100, 1'b0, 32'h104, 1'b1);
      upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h300, 6'd0, 1'b0);
      lookup("jal", 32'h200, 1'b1, 32'h300, 1'b1);
      bus.stall = 1'b0;
      tick();
      bus.stall = 1'b1;
      chk("jal_ghr", 32'(bus.pred_ghr), 32'd0);
      lookup("evicted", 32'h100, 1'b0, 32'h104, 1'b0);

      // gshare: train pc 0x104 under history 000101 (index 1^5)
      repeat (2) upd(32'h104, 1'b1, 1'b0, 1'b1, 32'h180, 6'b000101, 1'b0);
      upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h300, 6'b000101, 1'b1);
      chk("ghr_restore", 32'(bus.pred_ghr), 32'h05);
      lookup("gs_pred", 32'h104, 1'b1, 32'h180, 1'b1);
      bus.stall = 1'b0;
      tick();
      bus.stall = 1'b1;
      chk("ghr_shift", 32'(bus.pred_ghr), 32'h0B);

      // recovery beats the speculative shift in the same cycle
      upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h300, 6'b000101, 1'b1);
      lookup("gs_pred2", 32'h104, 1'b1, 32'h180, 1'b1);
      bus.stall = 1'b0;
      upd(32'h108, 1'b1, 1'b0, 1'b0, 32'h0, 6'b111000, 1'b1);
      bus.stall = 1'b1;
      chk("ghr_recover", 32'(bus.pred_ghr), 32'h30);

      // stalled lookup leaves history alone
      upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h300, 6'b000101, 1'b1);
      lookup("stall_pred", 32'h104, 1'b1, 32'h180, 1'b1);
      tick();
      chk("ghr_stall", 32'(bus.pred_ghr), 32'h05);

      chk("perf_br", bus.perf_branches, 32'(exp_br));
      chk("perf_mp", bus.perf_mispred,  32'(exp_mp));

      // mispredict counter sticks at all-ones
      force dut.perf_mispred_q = 32'hFFFF_FFFF;
      bus.upd_valid      = 1'b1;
      bus.upd_pc         = 32'h200;
      bus.upd_is_branch  = 1'b0;
      bus.upd_is_jump    = 1'b1;
      bus.upd_taken      = 1'b1;
      bus.upd_target     = 32'h300;
      bus.upd_ghr        = 6'd0;
      bus.upd_mispredict = 1'b1;
      #2;
      chk("perf_sat_next", dut.perf_mispred_d, 32'hFFFF_FFFF);
      tick();
      bus.upd_valid      = 1'b0;
      bus.upd_mispredict = 1'b0;
      release dut.perf_mispred_q;
      #1;
      chk("perf_sat", bus.perf_mispred, 32'hFFFF_FFFF);
      chk("perf_br_sat", bus.perf_branches, 32'(exp_br + 1));

      // reset mid-run wipes BTB, history and perf counters
      rstn = 1'b0;
      tick();
      tick();
      chk("rst2_ready",   32'(bus.ready),    32'd0);
      chk("rst2_ghr",     32'(bus.pred_ghr), 32'd0);
      chk("rst2_perf_br", bus.perf_branches, 32'd0);
      chk("rst2_perf_mp", bus.perf_mispred,  32'd0);
      rstn = 1'b1;
      wait_ready("init2_len");
      lookup("rst2_jal", 32'h200, 1'b0, 32'h204, 1'b0);
      lookup("rst2_br",  32'h104, 1'b0, 32'h108, 1'b0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
